fizzbuzz_seq: RTL and testbench
===============================

# fizzbuzz_seq

Sequential, parametrised FizzBuzz stream generator: on a start pulse it walks the integers 1..limit and emits one classified item per accepted handshake. Each item is a number plus a kind code (number / fizz / buzz / fizzbuzz). Classification uses two running residue counters rather than dividers, so the block closes timing at any WIDTH. It is the clocked successor to the combinational fizzbuzz classifier and feeds a downstream printer/UART formatter over a valid/ready stream.

## Interface
- WIDTH, 32: width of number, limit and statistics counters.
- FIZZ_DIV, 3: first divisor. Must be ≥2.
- BUZZ_DIV, 5: second divisor. Must be ≥2. May equal FIZZ_DIV; matching items are then FIZZBUZZ.
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
- limit  in  WIDTH  last number to emit; sampled on the accepted start.
- out_valid  out  1  item present on out_number/out_kind.
- out_ready  in  1  downstream accepts the item when high together with out_valid.
- out_number  out  WIDTH  current integer.
- out_kind  out  2  0 NUMBER, 1 FIZZ, 2 BUZZ, 3 FIZZBUZZ.
- busy  out  1  high in RUN.
- done  out  1  high in DONE, held until the next start or rst.
- cnt_fizz, cnt_buzz, cnt_fizzbuzz  out  WIDTH each  per-run kind counts; present only with FIZZBUZZ_STATS_EN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start: if limit==0, go to DONE with no items. Otherwise latch limit, number←1, residues←1 mod divisor, go to RUN.
- RUN: out_valid=1. Kind: FIZZBUZZ when both residues are 0, FIZZ when only the fizz residue is 0, BUZZ when only the buzz residue is 0, else NUMBER.
- On a handshake (out_valid & out_ready):
  - If number==latched limit, go to DONE.
  - Otherwise number+1, and each residue increments, wrapping divisor−1→0.
- Backpressure: while out_valid & !out_ready, out_number and out_kind are held stable.
- No wrap-around: the end test is done before increment, so limit = 2^WIDTH−1 emits that value last and stops, with no overflow to 0.
- start in RUN is ignored. The limit input is not re-sampled mid-run.
- rst at any time: state IDLE next cycle, any in-flight item dropped.
- Reset values: out_valid=0, busy=0, done=0, out_number=0, out_kind=0, all cnt_*=0.

## Timing
- start accepted at edge t: out_valid=1 with number 1 from cycle t+1.
- Throughput: one item per cycle while out_ready stays high.
- Last handshake at edge u: out_valid=0, busy=0, done=1 from cycle u+1.
- limit==0 start at edge t: done=1 from t+1, out_valid never asserts.
- Outputs are fully registered. out_kind and out_number change only on handshake or start.

## Configuration
- FIZZBUZZ_STATS_EN defined:
  - cnt_fizz, cnt_buzz and cnt_fizzbuzz ports exist.
  - Each counter increments on a handshake of its kind.
  - All three clear on an accepted start and on rst.
  - Values hold through DONE.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- fizzbuzz_pkg:
  - kind_t enum (KIND_NUMBER, KIND_FIZZ, KIND_BUZZ, KIND_FIZZBUZZ).
  - state_t enum (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module mod_counter (parameter MOD):
  - Residue counter with clear-to-1 on start and advance on an enable.
  - Flags zero = (residue==0).
  - Instantiated twice.

## Test plan
- limit=15, out_ready=1: 15 items, kinds N,N,F,N,B,F,N,N,F,B,N,F,N,N,FB; done at start+16; busy low after.
- limit=6, out_ready toggled 1,0,0,1 pattern: each item held stable until handshake; sequence identical to the no-stall case; no duplicate or dropped number.
- limit=0: done=1 the cycle after start, out_valid stays 0; re-start with limit=3 then emits 1,2,3(F).
- rst asserted while number=7 in RUN: next cycle IDLE, out_valid=0, done=0; start afterwards restarts at 1. Also, start pulsed in RUN is ignored and the sequence continues.
- FIZZ_DIV=2, BUZZ_DIV=3, limit=6: N,F,B,F,N,FB.
- FIZZBUZZ_STATS_EN, limit=100: cnt_fizz=27, cnt_buzz=14, cnt_fizzbuzz=6 in DONE; all counters 0 after the next start.

Source files
------------

// File: rtl/fizzbuzz_pkg.sv
// Shared types for the FizzBuzz stream generator: item kinds, FSM states and the
// residue-to-kind mapping used by both the datapath and the optional statistics.
package fizzbuzz_pkg;

    typedef enum logic [1:0] {
        KIND_NUMBER   = 2'd0,
        KIND_FIZZ     = 2'd1,
        KIND_BUZZ     = 2'd2,
        KIND_FIZZBUZZ = 2'd3
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Bit 0 of the kind code means "divisible by the fizz divisor", bit 1 the buzz divisor.
    function automatic kind_t classify(input logic fizzHit, input logic buzzHit);
        return kind_t'({buzzHit, fizzHit});
    endfunction

endpackage

// File: rtl/fizzbuzz_seq_mod_counter.sv
// Residue counter modulo MOD: cleared to 1 when a run starts, advanced once per emitted item.
module mod_counter #(
    parameter int MOD = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_zero
);

    localparam int RW = $clog2(MOD);
    localparam logic [RW-1:0] LAST = RW'(MOD - 1);

    logic [RW-1:0] r_residue;

    // Reset to 1 as well so the idle kind decodes to NUMBER.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_residue <= RW'(1);
        end else if (i_clear) begin
            r_residue <= RW'(1);
        end else if (i_advance) begin
            r_residue <= (r_residue == LAST) ? '0 : r_residue + 1'b1;
        end
    end

    assign o_zero = (r_residue == '0);

endmodule

// File: rtl/fizzbuzz_seq.sv
// Sequential FizzBuzz stream generator over a valid/ready handshake.
// Define FIZZBUZZ_STATS_EN to add per-run fizz/buzz/fizzbuzz item counters.
module fizzbuzz_seq
    import fizzbuzz_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FIZZ_DIV = 3,
    parameter int BUZZ_DIV = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_number,
    output logic [1:0]       o_out_kind,
    output logic             o_busy,
    output logic             o_done
`ifdef FIZZBUZZ_STATS_EN
    ,
    output logic [WIDTH-1:0] o_cnt_fizz,
    output logic [WIDTH-1:0] o_cnt_buzz,
    output logic [WIDTH-1:0] o_cnt_fizzbuzz
`endif
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_limit;
    logic [WIDTH-1:0] r_number;
    logic             w_fire;
    logic             w_load;
    logic             w_advance;
    logic             w_clear_stats;
    logic             w_fizz_zero;
    logic             w_buzz_zero;
    kind_t            w_kind;

    assign w_fire = (r_state == ST_RUN) && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The end test compares before incrementing, so limit = all-ones never wraps to 0.
    always_comb begin
        w_next_state  = r_state;
        w_load        = 1'b0;
        w_advance     = 1'b0;
        w_clear_stats = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_clear_stats = 1'b1;
                    if (i_limit == '0) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_RUN;
                        w_load       = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_fire) begin
                    if (r_number == r_limit) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_limit  <= '0;
            r_number <= '0;
        end else if (w_load) begin
            r_limit  <= i_limit;
            r_number <= WIDTH'(1);
        end else if (w_advance) begin
            r_number <= r_number + 1'b1;
        end
    end

    mod_counter #(.MOD(FIZZ_DIV)) u_fizz_residue (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_load),
        .i_advance (w_advance),
        .o_zero    (w_fizz_zero)
    );

    mod_counter #(.MOD(BUZZ_DIV)) u_buzz_residue (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_load),
        .i_advance (w_advance),
        .o_zero    (w_buzz_zero)
    );

    // Kind is a pure decode of the residue registers, so it only moves on handshake or start.
    assign w_kind       = classify(w_fizz_zero, w_buzz_zero);
    assign o_out_kind   = w_kind;
    assign o_out_number = r_number;
    assign o_out_valid  = (r_state == ST_RUN);
    assign o_busy       = (r_state == ST_RUN);
    assign o_done       = (r_state == ST_DONE);

`ifdef FIZZBUZZ_STATS_EN
    logic [WIDTH-1:0] r_cnt_fizz;
    logic [WIDTH-1:0] r_cnt_buzz;
    logic [WIDTH-1:0] r_cnt_fizzbuzz;

    always_ff @(posedge i_clk) begin
        if (i_rst || w_clear_stats) begin
            r_cnt_fizz     <= '0;
            r_cnt_buzz     <= '0;
            r_cnt_fizzbuzz <= '0;
        end else if (w_fire) begin
            case (w_kind)
                KIND_FIZZ:     r_cnt_fizz     <= r_cnt_fizz + 1'b1;
                KIND_BUZZ:     r_cnt_buzz     <= r_cnt_buzz + 1'b1;
                KIND_FIZZBUZZ: r_cnt_fizzbuzz <= r_cnt_fizzbuzz + 1'b1;
                default:       ;
            endcase
        end
    end

    assign o_cnt_fizz     = r_cnt_fizz;
    assign o_cnt_buzz     = r_cnt_buzz;
    assign o_cnt_fizzbuzz = r_cnt_fizzbuzz;
`endif

endmodule

// File: tb/tb_fizzbuzz_seq.sv
// Self-checking bench for fizzbuzz_seq: a 32-bit 3/5 instance and an 8-bit 2/3 instance
// driven with random backpressure and compared against an arithmetic FizzBuzz model.
module tb_fizzbuzz_seq;

    localparam int W1 = 32;
    localparam int W2 = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start1, ready1, start2, ready2;
    logic [W1-1:0] limit1;
    logic [W2-1:0] limit2;
    logic          valid1, busy1, done1, valid2, busy2, done2;
    logic [W1-1:0] number1;
    logic [W2-1:0] number2;
    logic [1:0]    kind1, kind2;
`ifdef FIZZBUZZ_STATS_EN
    logic [W1-1:0] cntFizz1, cntBuzz1, cntFizzBuzz1;
    logic [W2-1:0] cntFizz2, cntBuzz2, cntFizzBuzz2;
`endif

    fizzbuzz_seq #(.WIDTH(W1), .FIZZ_DIV(3), .BUZZ_DIV(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_limit(limit1),
        .o_out_valid(valid1), .i_out_ready(ready1), .o_out_number(number1),
        .o_out_kind(kind1), .o_busy(busy1), .o_done(done1)
`ifdef FIZZBUZZ_STATS_EN
        , .o_cnt_fizz(cntFizz1), .o_cnt_buzz(cntBuzz1), .o_cnt_fizzbuzz(cntFizzBuzz1)
`endif
    );

    fizzbuzz_seq #(.WIDTH(W2), .FIZZ_DIV(2), .BUZZ_DIV(3)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_limit(limit2),
        .o_out_valid(valid2), .i_out_ready(ready2), .o_out_number(number2),
        .o_out_kind(kind2), .o_busy(busy2), .o_done(done2)
`ifdef FIZZBUZZ_STATS_EN
        , .o_cnt_fizz(cntFizz2), .o_cnt_buzz(cntBuzz2), .o_cnt_fizzbuzz(cntFizzBuzz2)
`endif
    );

    int assertCount = 0;
    int failCount   = 0;
    int qNum[$];
    int qKind[$];
    int stallErrors;
    int elapsed;
    bit timedOut;

    // Reference classification straight from the divisibility rules.
    function automatic int refKind(input int n, input int f, input int b);
        bit fz = (n % f) == 0;
        bit bz = (n % b) == 0;
        if (fz && bz) return 3;
        if (fz) return 1;
        if (bz) return 2;
        return 0;
    endfunction

    // Pulse start for one cycle on the selected instance; returns at the first cycle of the run.
    task automatic applyStimulus(input int which, input int lim);
        @(negedge clk);
        if (which == 1) begin
            start1 = 1'b1;
            limit1 = W1'(lim);
        end else begin
            start2 = 1'b1;
            limit2 = W2'(lim);
        end
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Drive ready (0: always, 1: 1,0,0,1 pattern, 2: random) and record every accepted item.
    task automatic collect(input int which, input int mode, input int pulseAt, input int maxCycles);
        int  prevNum, prevKind, n, k;
        bit  v, d, r, prevStall;
        qNum.delete();
        qKind.delete();
        stallErrors = 0;
        elapsed     = 0;
        timedOut    = 1'b0;
        prevStall   = 1'b0;
        prevNum     = -1;
        prevKind    = -1;
        while (1) begin
            v = (which == 1) ? valid1 : valid2;
            d = (which == 1) ? done1 : done2;
            n = (which == 1) ? int'(number1) : int'(number2);
            k = (which == 1) ? int'(kind1) : int'(kind2);
            if (d) break;
            if (elapsed >= maxCycles) begin
                timedOut = 1'b1;
                break;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (elapsed % 4 == 0) || (elapsed % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            if (v && prevStall && (n != prevNum || k != prevKind)) stallErrors++;
            if (v && r) begin
                qNum.push_back(n);
                qKind.push_back(k);
            end
            prevStall = v && !r;
            prevNum   = n;
            prevKind  = k;
            if (which == 1) ready1 = r;
            else ready2 = r;
            if (elapsed == pulseAt) begin
                start1 = 1'b1;
                limit1 = W1'(2);
            end
            @(negedge clk);
            start1 = 1'b0;
            elapsed++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
        limit1 = '0; limit2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        assertCount++;
        if ({valid1, busy1, done1, kind1} !== 5'b0 || number1 !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_dut1: got v=%b b=%b d=%b k=%0d n=%0d expected all 0", valid1, busy1, done1, kind1, number1);
        end
        assertCount++;
        if ({valid2, busy2, done2, kind2} !== 5'b0 || number2 !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_dut2: got v=%b b=%b d=%b k=%0d n=%0d expected all 0", valid2, busy2, done2, kind2, number2);
        end
`ifdef FIZZBUZZ_STATS_EN
        assertCount++;
        if (cntFizz1 !== '0 || cntBuzz1 !== '0 || cntFizzBuzz1 !== '0 || cntFizz2 !== '0 || cntBuzz2 !== '0 || cntFizzBuzz2 !== '0) begin
            failCount++;
            $display("[TB] FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", cntFizz1, cntBuzz1, cntFizzBuzz1);
        end
`endif
    endtask

    task automatic test_basic;
        applyStimulus(1, 15);
        collect(1, 0, -1, 100);
        assertCount++;
        if (timedOut || elapsed != 15 || qNum.size() != 15) begin
            failCount++;
            $display("[TB] FAIL basic_length: got cycles=%0d items=%0d timeout=%0b expected 15/15/0", elapsed, qNum.size(), timedOut);
        end
        for (int i = 0; i < qNum.size(); i++) begin
            assertCount++;
            if (qNum[i] !== i + 1 || qKind[i] !== refKind(i + 1, 3, 5)) begin
                failCount++;
                $display("[TB] FAIL basic_item%0d: got n=%0d k=%0d expected n=%0d k=%0d", i, qNum[i], qKind[i], i + 1, refKind(i + 1, 3, 5));
            end
        end
        assertCount++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || valid1 !== 1'b0 || number1 !== W1'(15)) begin
            failCount++;
            $display("[TB] FAIL basic_done: got d=%b b=%b v=%b n=%0d expected 1/0/0/15", done1, busy1, valid1, number1);
        end
    endtask

    task automatic test_backpressure;
        applyStimulus(1, 6);
        collect(1, 1, -1, 100);
        assertCount++;
        if (timedOut || qNum.size() != 6 || stallErrors != 0) begin
            failCount++;
            $display("[TB] FAIL stall_len: got items=%0d stallErr=%0d timeout=%0b expected 6/0/0", qNum.size(), stallErrors, timedOut);
        end
        for (int i = 0; i < qNum.size(); i++) begin
            assertCount++;
            if (qNum[i] !== i + 1 || qKind[i] !== refKind(i + 1, 3, 5)) begin
                failCount++;
                $display("[TB] FAIL stall_item%0d: got n=%0d k=%0d expected n=%0d k=%0d", i, qNum[i], qKind[i], i + 1, refKind(i + 1, 3, 5));
            end
        end
    endtask

    task automatic test_random;
        int lim, bad;
        repeat (4) begin
            lim = $urandom_range(1, 40);
            applyStimulus(1, lim);
            collect(1, 2, -1, 2000);
            bad = 0;
            for (int i = 0; i < qNum.size(); i++)
                if (qNum[i] !== i + 1 || qKind[i] !== refKind(i + 1, 3, 5)) bad++;
            assertCount++;
            if (timedOut || qNum.size() != lim || stallErrors != 0 || bad != 0) begin
                failCount++;
                $display("[TB] FAIL random_run lim=%0d: got items=%0d wrong=%0d stallErr=%0d timeout=%0b expected %0d/0/0/0", lim, qNum.size(), bad, stallErrors, timedOut, lim);
            end
        end
    endtask

    task automatic test_zero_limit;
        int sawValid = 0;
        applyStimulus(1, 0);
        assertCount++;
        if (done1 !== 1'b1 || valid1 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL zero_done: got d=%b v=%b expected 1/0", done1, valid1);
        end
        repeat (4) begin
            @(negedge clk);
            if (valid1 !== 1'b0) sawValid++;
        end
        assertCount++;
        if (sawValid != 0) begin
            failCount++;
            $display("[TB] FAIL zero_novalid: got %0d valid cycles expected 0", sawValid);
        end
        applyStimulus(1, 3);
        collect(1, 0, -1, 100);
        assertCount++;
        if (timedOut || qNum.size() != 3 || qNum[0] !== 1 || qNum[2] !== 3 || qKind[0] !== 0 || qKind[1] !== 0 || qKind[2] !== 1) begin
            failCount++;
            $display("[TB] FAIL zero_restart: got items=%0d expected 1(N),2(N),3(F)", qNum.size());
        end
    endtask

    task automatic test_reset_midrun;
        bit found = 1'b0;
        applyStimulus(1, 20);
        ready1 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (number1 == W1'(7)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        assertCount++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL midrun_reach7: got n=%0d expected 7 within 50 cycles", number1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        assertCount++;
        if (valid1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midrun_idle: got v=%b d=%b b=%b expected 0/0/0", valid1, done1, busy1);
        end
        applyStimulus(1, 4);
        assertCount++;
        if (valid1 !== 1'b1 || number1 !== W1'(1)) begin
            failCount++;
            $display("[TB] FAIL midrun_restart: got v=%b n=%0d expected 1/1", valid1, number1);
        end
        collect(1, 2, -1, 500);
        assertCount++;
        if (timedOut || qNum.size() != 4 || qNum[3] !== 4 || qKind[2] !== 1) begin
            failCount++;
            $display("[TB] FAIL midrun_seq: got items=%0d expected 4 ending at 4", qNum.size());
        end
    endtask

    task automatic test_start_ignored;
        int bad = 0;
        applyStimulus(1, 10);
        collect(1, 0, 3, 100);
        for (int i = 0; i < qNum.size(); i++)
            if (qNum[i] !== i + 1 || qKind[i] !== refKind(i + 1, 3, 5)) bad++;
        assertCount++;
        if (timedOut || qNum.size() != 10 || bad != 0) begin
            failCount++;
            $display("[TB] FAIL start_in_run: got items=%0d wrong=%0d expected 10/0", qNum.size(), bad);
        end
    endtask

    task automatic test_alt_divisors;
        int bad = 0;
        applyStimulus(2, 6);
        collect(2, 0, -1, 100);
        for (int i = 0; i < qNum.size(); i++) begin
            assertCount++;
            if (qNum[i] !== i + 1 || qKind[i] !== refKind(i + 1, 2, 3)) begin
                failCount++;
                $display("[TB] FAIL alt_item%0d: got n=%0d k=%0d expected n=%0d k=%0d", i, qNum[i], qKind[i], i + 1, refKind(i + 1, 2, 3));
            end
        end
        assertCount++;
        if (timedOut || qNum.size() != 6) begin
            failCount++;
            $display("[TB] FAIL alt_len: got %0d expected 6", qNum.size());
        end
        applyStimulus(2, 255);
        collect(2, 2, -1, 3000);
        for (int i = 0; i < qNum.size(); i++)
            if (qNum[i] !== i + 1 || qKind[i] !== refKind(i + 1, 2, 3)) bad++;
        assertCount++;
        if (timedOut || qNum.size() != 255 || bad != 0 || done2 !== 1'b1 || number2 !== 8'd255) begin
            failCount++;
            $display("[TB] FAIL alt_maxlimit: got items=%0d wrong=%0d d=%b n=%0d expected 255/0/1/255", qNum.size(), bad, done2, number2);
        end
    endtask

`ifdef FIZZBUZZ_STATS_EN
    task automatic test_stats;
        int expF = 0, expB = 0, expFB = 0;
        for (int n = 1; n <= 100; n++) begin
            if (refKind(n, 3, 5) == 1) expF++;
            if (refKind(n, 3, 5) == 2) expB++;
            if (refKind(n, 3, 5) == 3) expFB++;
        end
        applyStimulus(1, 100);
        collect(1, 2, -1, 2000);
        assertCount++;
        if (cntFizz1 !== W1'(27) || cntBuzz1 !== W1'(14) || cntFizzBuzz1 !== W1'(6) || expF != 27 || expB != 14 || expFB != 6) begin
            failCount++;
            $display("[TB] FAIL stats_counts: got %0d/%0d/%0d expected 27/14/6", cntFizz1, cntBuzz1, cntFizzBuzz1);
        end
        applyStimulus(1, 5);
        assertCount++;
        if (cntFizz1 !== '0 || cntBuzz1 !== '0 || cntFizzBuzz1 !== '0) begin
            failCount++;
            $display("[TB] FAIL stats_clear: got %0d/%0d/%0d expected 0/0/0", cntFizz1, cntBuzz1, cntFizzBuzz1);
        end
        collect(1, 0, -1, 100);
    endtask
`endif

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting fizzbuzz_seq bench");
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_zero_limit();
        test_reset_midrun();
        test_start_ignored();
        test_alt_divisors();
`ifdef FIZZBUZZ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
